// File: rtl/tff_counter_if.sv
// Control and status bundle of the toggle-flip-flop counter.
// Control group (en/up_dn/clr/load/load_val) is driven by the user; status comes back from the counter.
// No flow control: the counter accepts a command on every clk edge.
interface tff_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             div_out;

    // User side: issues commands, observes count and flags
    modport master (
        output en, up_dn, clr, load, load_val,
        input  q, tc, div_out
    );

    // Counter side
    modport slave (
        input  en, up_dn, clr, load, load_val,
        output q, tc, div_out
    );
endinterface

// File: rtl/tff_counter.sv
// Modulo-MOD up/down counter built from WIDTH toggle flip-flops, with load/clear, terminal count and divider output.
// Latency: q/div_out one clk after the sampling edge; tc is combinational (zero latency).
// No backpressure: one command is accepted on every clk edge. Build macro TFF_COUNTER_SAT_EN selects saturating mode.
module tff_counter #(
    parameter int      WIDTH = 8,
    parameter longint  MOD   = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    tff_counter_if.slave bus
);
    // Top of the count range; truncation is exact for MOD == 2^WIDTH (all ones)
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max;
    logic             at_zero;
    logic             tc_c;

    assign at_max  = (q_r == MAX_VAL);
    assign at_zero = (q_r == '0);

    // Terminal count marks the edge that wraps (or, when saturating, the parked cycle).
    // Gated by reset_n so it reads 0 while the counter is held in reset.
    assign tc_c = reset_n & bus.en & ~bus.clr & ~bus.load &
                  (bus.up_dn ? at_max : at_zero);

    // Loaded values beyond the modulus are clamped to the top of the range
    assign load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

    // Toggle vector: bit i flips when all lower bits are 1 (up) or all 0 (down); boundary overrides it
    always_comb begin
        logic carry;
        t     = '0;
        carry = bus.en;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]  = carry;
            carry = carry & (bus.up_dn ? q_r[i] : ~q_r[i]);
        end
`ifdef TFF_COUNTER_SAT_EN
        // Parked at the boundary: no bit toggles
        if (tc_c) begin
            t = '0;
        end
`else
        // Wrap: toggle exactly the bits that differ from the wrap target
        if (tc_c) begin
            t = bus.up_dn ? q_r : (q_r ^ MAX_VAL);
        end
`endif
    end

    // Count register: clr beats load beats count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= '0;
        end else if (bus.clr) begin
            q_r <= '0;
        end else if (bus.load) begin
            q_r <= load_clamped;
        end else begin
            q_r <= q_r ^ t;
        end
    end

    assign bus.q  = q_r;
    assign bus.tc = tc_c;

`ifdef TFF_COUNTER_SAT_EN
    // No wraps happen in saturating mode, so the divider output is constant
    assign bus.div_out = 1'b0;
`else
    logic div_r;

    // Divider flips on every wrap, giving a 2*MOD period with en held high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r <= 1'b0;
        end else if (tc_c) begin
            div_r <= ~div_r;
        end
    end

    assign bus.div_out = div_r;
`endif
endmodule

// File: tb/tb_tff_counter.sv
// Self-checking bench for tff_counter: scoreboard + behavioural model on a WIDTH=4/MOD=10 instance,
// directed checks for async reset and for natural rollover on a WIDTH=8/MOD=256 instance.
// Honours TFF_COUNTER_SAT_EN so the same bench covers both builds.
module tb_tff_counter;
    localparam int W = 4;
    localparam int M = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tff_counter_if #(.WIDTH(W)) bus1 ();
    tff_counter_if #(.WIDTH(8)) bus2 ();

    tff_counter #(.WIDTH(W), .MOD(M)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    tff_counter #(.WIDTH(8), .MOD(256)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    typedef struct {
        bit tc;
        int q;
        bit dv;
    } rec_t;

    rec_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_q   = 0;
    bit   m_div = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one command at the falling edge and record what the counter must show
    task automatic step(input bit e, input bit u, input bit c, input bit l, input int lv);
        rec_t r;
        int   lim;
        @(negedge clk);
        bus1.en       = e;
        bus1.up_dn    = u;
        bus1.clr      = c;
        bus1.load     = l;
        bus1.load_val = W'(lv);
        r.tc = e && !c && !l && (u ? (m_q == M - 1) : (m_q == 0));
        if (c) begin
            m_q = 0;
        end else if (l) begin
            lim = (lv > M - 1) ? M - 1 : lv;
            m_q = lim;
        end else if (e) begin
`ifdef TFF_COUNTER_SAT_EN
            if (u) m_q = (m_q == M - 1) ? m_q : m_q + 1;
            else   m_q = (m_q == 0) ? 0 : m_q - 1;
`else
            if (r.tc) m_div = !m_div;
            m_q = u ? (m_q + 1) % M : (m_q + M - 1) % M;
`endif
        end
        r.q  = m_q;
        r.dv = m_div;
        sb.push_back(r);
    endtask

    // Monitor: tc sampled mid-cycle before the edge, q/div_out just after it
    initial begin
        rec_t r;
        bit   tc_s;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() != 0) begin
                tc_s = bus1.tc;
                @(posedge clk);
                #1;
                r = sb.pop_front();
                chk("tc", int'(tc_s), int'(r.tc));
                chk("q", int'(bus1.q), r.q);
                chk("div_out", int'(bus1.div_out), int'(r.dv));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit e, u, c, l;
        int lv;

        bus1.en = 1'b1; bus1.up_dn = 1'b0; bus1.clr = 1'b0; bus1.load = 1'b0; bus1.load_val = '0;
        bus2.en = 1'b0; bus2.up_dn = 1'b1; bus2.clr = 1'b0; bus2.load = 1'b0; bus2.load_val = '0;

        // Reset state: q=0 at en=1/down must still give tc=0
        #2;
        chk("reset_q", int'(bus1.q), 0);
        chk("reset_div", int'(bus1.div_out), 0);
        chk("reset_tc", int'(bus1.tc), 0);
        bus1.en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Up count through two wraps and a bit
        for (int i = 0; i < 25; i++) step(1, 1, 0, 0, 0);
        // Down from 0
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0);
        // Load clamp, clr priority, load beats en, hold
        step(0, 1, 0, 1, 13);
        step(0, 1, 1, 1, 5);
        step(1, 1, 0, 1, 3);
        step(1, 1, 0, 1, 9);
        step(1, 1, 0, 1, 9);
        step(0, 0, 0, 0, 0);
        // Direction flips around the boundaries
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1);
            c  = ($urandom_range(0, 15) == 0);
            l  = ($urandom_range(0, 7) == 0);
            lv = $urandom_range(0, 15);
            step(e, u, c, l, lv);
        end
        drain();

        // Count to 7 past one wrap, then hit reset mid-cycle
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 1, 0, 0, 0);
        drain();
        chk("pre_reset_q", int'(bus1.q), m_q);
        chk("pre_reset_div", int'(bus1.div_out), int'(m_div));
        @(posedge clk);
        #3;
        bus1.up_dn = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_q", int'(bus1.q), 0);
        chk("async_div", int'(bus1.div_out), 0);
        chk("async_tc", int'(bus1.tc), 0);
        m_q   = 0;
        m_div = 1'b0;
        bus1.en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        drain();

        // WIDTH=8 MOD=256: rollover at 255, then reverse at 0
        @(negedge clk);
        bus2.load = 1'b1; bus2.load_val = 8'd255; bus2.en = 1'b0;
        @(negedge clk);
        bus2.load = 1'b0; bus2.en = 1'b1; bus2.up_dn = 1'b1;
        #3;
        chk("w8_tc_up", int'(bus2.tc), 1);
        @(posedge clk);
        #1;
`ifdef TFF_COUNTER_SAT_EN
        chk("w8_q_up", int'(bus2.q), 255);
        chk("w8_div_up", int'(bus2.div_out), 0);
`else
        chk("w8_q_up", int'(bus2.q), 0);
        chk("w8_div_up", int'(bus2.div_out), 1);
`endif
        @(negedge clk);
        bus2.up_dn = 1'b0;
        #3;
`ifdef TFF_COUNTER_SAT_EN
        chk("w8_tc_dn", int'(bus2.tc), 0);
`else
        chk("w8_tc_dn", int'(bus2.tc), 1);
`endif
        @(posedge clk);
        #1;
`ifdef TFF_COUNTER_SAT_EN
        chk("w8_q_dn", int'(bus2.q), 254);
`else
        chk("w8_q_dn", int'(bus2.q), 255);
`endif
        chk("w8_div_dn", int'(bus2.div_out), 0);
        @(negedge clk);
        bus2.en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
